// File: rtl/ecc_pkg.sv
// rtl/ecc_pkg.sv - shared SECDED layout helpers for the encoder and decoder
package ecc_pkg;

  localparam int MAX_K = 120;
  localparam int MAX_N = 127;

  // Smallest m with 2**m >= m + k + 1.
  function automatic int calc_m(input int k);
    int m;
    m = 1;
    for (int i = 0; i < 8; i++) begin
      if ((1 << m) < m + k + 1) m = m + 1;
    end
    return m;
  endfunction

  function automatic logic is_pow2(input int p);
    return (p > 0) && ((p & (p - 1)) == 0);
  endfunction

  // Returns cw[n:1] in bits [n:1] and p0 in bit 0; bits above n are zero.
  function automatic logic [MAX_N:0] ecc_encode(input logic [MAX_K-1:0] d, input int k);
    logic [MAX_N:0] w;
    logic           par;
    int             m;
    int             n;
    int             di;
    m  = calc_m(k);
    n  = m + k;
    w  = '0;
    di = 0;
    // Data fills the non-power-of-2 positions in ascending order.
    for (int p = 1; p <= MAX_N; p++) begin
      if (p <= n && !is_pow2(p) && di < MAX_K) begin
        w[p] = d[di];
        di   = di + 1;
      end
    end
    // Parity at 2**i covers every position with index bit i set.
    for (int i = 0; i < 8; i++) begin
      if (i < m) begin
        par = 1'b0;
        for (int p = 1; p <= MAX_N; p++) begin
          if (p <= n && p[i]) par = par ^ w[p];
        end
        w[1 << i] = par;
      end
    end
    // Overall parity makes the whole word even.
    par = 1'b0;
    for (int p = 1; p <= MAX_N; p++) begin
      if (p <= n) par = par ^ w[p];
    end
    w[0] = par;
    return w;
  endfunction

endpackage

// File: rtl/ecc_pipe_stage.sv
// rtl/ecc_pipe_stage.sv - valid/ready register slice with clock enable
module ecc_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clkena_i,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  // The slice accepts when empty or when its word leaves this cycle.
  assign in_ready = ~out_valid | out_ready;

  // Load a new word, or go empty, only when the slot is free and enabled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (clkena_i && in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end

endmodule

// File: rtl/ecc_enc_stream.sv
// rtl/ecc_enc_stream.sv - streaming SECDED encoder with error injection
module ecc_enc_stream
  import ecc_pkg::*;
#(
  parameter  int K       = 8,
  parameter  int LATENCY = 1,
  parameter  int P0_LSB  = 1,
  localparam int M       = calc_m(K),
  localparam int N       = M + K
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clkena_i,
  input  logic [K-1:0] d_i,
  input  logic         d_valid_i,
  output logic         d_ready_o,
  output logic [N:0]   q_o,
  output logic         q_valid_o,
  input  logic         q_ready_i,
  input  logic         inj_arm_i,
  input  logic [N:0]   inj_mask_i,
  output logic         inj_pending_o,
  output logic         inj_done_o,
  output logic [31:0]  cw_cnt_o
);

  function automatic logic [N:0] encode_word(input logic [K-1:0] d);
    logic [MAX_K-1:0] dw;
    logic [MAX_N:0]   w;
    dw        = '0;
    dw[K-1:0] = d;
    w         = ecc_encode(dw, K);
    if (P0_LSB != 0) return w[N:0];
    else             return {w[0], w[N:1]};
  endfunction

  logic       ready_ok;
  logic       s1_in_ready;
  logic       accept;
  logic       inj_use;
  logic [N:0] inj_mask_q;
  logic [N:0] eff_mask;

  // Input ready stays low until the first edge after reset release.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ready_ok <= 1'b0;
    else         ready_ok <= 1'b1;
  end

  assign d_ready_o = ready_ok & s1_in_ready;
  assign accept    = d_valid_i & d_ready_o & clkena_i;
  assign inj_use   = inj_arm_i | inj_pending_o;
  // A same-cycle arm overrides any older pending mask.
  assign eff_mask  = inj_arm_i ? inj_mask_i : (inj_pending_o ? inj_mask_q : '0);

  // Single-slot injection: arm latches a mask, the next accepted word consumes it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inj_pending_o <= 1'b0;
      inj_done_o    <= 1'b0;
      inj_mask_q    <= '0;
    end else if (clkena_i) begin
      if (accept && inj_use) begin
        inj_pending_o <= 1'b0;
        inj_done_o    <= 1'b1;
      end else begin
        inj_done_o <= 1'b0;
        if (inj_arm_i) begin
          inj_pending_o <= 1'b1;
          inj_mask_q    <= inj_mask_i;
        end
      end
    end
  end

  // Count delivered codewords, wrapping naturally at 32 bits.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                  cw_cnt_o <= '0;
    else if (clkena_i && q_valid_o && q_ready_i) cw_cnt_o <= cw_cnt_o + 32'd1;
  end

  generate
    if (LATENCY == 2) begin : g_lat2
      // Stage 1 carries the raw data plus the mask it was accepted with.
      logic [K+N:0] s1_in;
      logic [K+N:0] s1_data;
      logic         s1_valid;
      logic         s2_in_ready;
      logic [N:0]   s2_in;

      assign s1_in = {eff_mask, d_i};
      assign s2_in = encode_word(s1_data[K-1:0]) ^ s1_data[K+N:K];

      ecc_pipe_stage #(.W(K + N + 1)) u_s1 (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clkena_i  (clkena_i),
        .in_data   (s1_in),
        .in_valid  (d_valid_i & ready_ok),
        .in_ready  (s1_in_ready),
        .out_data  (s1_data),
        .out_valid (s1_valid),
        .out_ready (s2_in_ready)
      );

      ecc_pipe_stage #(.W(N + 1)) u_s2 (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clkena_i  (clkena_i),
        .in_data   (s2_in),
        .in_valid  (s1_valid),
        .in_ready  (s2_in_ready),
        .out_data  (q_o),
        .out_valid (q_valid_o),
        .out_ready (q_ready_i)
      );
    end else begin : g_lat1
      logic [N:0] s1_in;

      assign s1_in = encode_word(d_i) ^ eff_mask;

      ecc_pipe_stage #(.W(N + 1)) u_s1 (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clkena_i  (clkena_i),
        .in_data   (s1_in),
        .in_valid  (d_valid_i & ready_ok),
        .in_ready  (s1_in_ready),
        .out_data  (q_o),
        .out_valid (q_valid_o),
        .out_ready (q_ready_i)
      );
    end
  endgenerate

endmodule
